// File: rtl/ex_mem_stage_buf.sv
// EX->MEM stage register, 1-cycle latency, valid/ready with flush and optional 2-entry skid.
// Backpressure: SKID=0 ready_o follows ready_i combinationally; SKID=1 ready_o decodes registered state.
module ex_mem_stage_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2,
  parameter int MEM_W  = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [MEM_W-1:0]  mem_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] rtdata_i,
  input  logic [ADDR_W-1:0] writeaddr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [MEM_W-1:0]  mem_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] rtdata_o,
  output logic [ADDR_W-1:0] writeaddr_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [MEM_W-1:0]  mem;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rtdata;
    logic [ADDR_W-1:0] waddr;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t           r_state;
  entry_t           r_main;
  entry_t           r_skid;
  logic [CNT_W-1:0] r_stall_cnt;

  entry_t w_in;
  logic   w_valid;
  logic   w_ready;
  logic   w_accept;
  logic   w_release;

  assign w_in = '{wb: wb_i, mem: mem_i, result: result_i, rtdata: rtdata_i, waddr: writeaddr_i};

  assign w_valid = (r_state != ST_EMPTY);

  // Skid mode never looks at ready_i here, which keeps the upstream ready path register-driven.
  always_comb begin
    w_ready = 1'b0;
    if (SKID != 0) begin
      w_ready = !rst_i && (r_state != ST_SKID);
    end else begin
      w_ready = !rst_i && (!w_valid || ready_i);
    end
  end

  assign w_accept  = valid_i && w_ready;
  assign w_release = w_valid && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main  <= w_in;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          // Without skid, accept in FULL implies release, so the skid branch is unreachable.
          if (w_accept && w_release) begin
            r_main <= w_in;
          end else if (w_accept) begin
            r_skid  <= w_in;
            r_state <= ST_SKID;
          end else if (w_release) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_release) begin
            r_main  <= r_skid;
            r_state <= ST_FULL;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !ready_i && !flush_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign ready_o     = w_ready;
  assign valid_o     = w_valid;
  assign wb_o        = w_valid ? r_main.wb  : '0;
  assign mem_o       = w_valid ? r_main.mem : '0;
  assign result_o    = r_main.result;
  assign rtdata_o    = r_main.rtdata;
  assign writeaddr_o = r_main.waddr;
  assign stall_cnt_o = r_stall_cnt;

endmodule
